bcd_countup_timer: RTL and testbench
====================================

Name: bcd_countup_timer

Overview:
- Two-digit BCD count-up timer, the up-direction companion to the existing countdown timer.
- Counts from 00 to a latched target value, one step per tick, under a start/pause pushbutton and an enable switch.
- Asserts done on reaching the target.
- Sits beside the countdown block; it consumes the same preset digits and tick enable, and drives the same digit display path.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on pb (minimum 2).
- MAX_DIGIT, 9, largest legal BCD digit; target digits above this are clamped to it.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle count enable, synchronous to clk (1 Hz strobe in system use).
- sw  input  1  enable switch, level; low suspends counting without changing state.
- pb  input  1  start/pause pushbutton, raw level; synchronized and rising-edge detected internally.
- clr  input  1  synchronous clear pulse; returns the block to IDLE with count 00.
- tgt_ones  input  4  target ones digit (BCD).
- tgt_tens  input  4  target tens digit (BCD).
- ones  output  4  current ones digit (BCD).
- tens  output  4  current tens digit (BCD).
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- done_pulse  output  1  one-cycle strobe on entry to DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - ones=0, tens=0, running=0, done=0, done_pulse=0.
  - Synchronizer, edge-detect flops and latched target are all cleared.
- pb path:
  - SYNC_STAGES flops, then an edge register.
  - pb_rise is asserted for exactly one cycle, SYNC_STAGES+1 clk edges after pb first samples high.
  - A held pb generates no further edges.
- States are IDLE, RUN, PAUSE and DONE.
- IDLE:
  - Count is held at 00.
  - On pb_rise, latch the target with each digit clamped to MAX_DIGIT.
  - If the clamped target is 00, go to DONE. Otherwise go to RUN.
  - A tick in the same cycle is ignored.
- RUN:
  - On tick with sw=1, increment the count:
    - If ones < 9, ones+1.
    - If ones == 9, ones becomes 0 and tens becomes tens+1.
  - If the incremented value equals the latched target, go to DONE in the same edge.
  - On pb_rise, go to PAUSE. A coincident tick is discarded.
- PAUSE:
  - Count is held.
  - On pb_rise, go to RUN. A coincident tick is discarded.
- DONE:
  - Count holds at the target.
  - done=1. done_pulse=1 only on the first DONE cycle.
  - On pb_rise, go to IDLE with count 00.
- sw=0 in any state: ticks are ignored. pb and clr still act.
- clr has priority over pb_rise and tick. From any state it sets count 00 and goes to IDLE next edge, with done_pulse=0.
- Target inputs are sampled only on the IDLE to RUN/DONE transition. Changes mid-run have no effect.
- The count never exceeds 99 and never passes the target, because the target is at most 99 and counting starts at 00. No wrap logic is required.
- Outputs running, done and done_pulse are registered.
- ones and tens update on the same edge as the state change.

Test Plan:
- Reset mid-RUN at count 37: drive rst_n low -> ones=0, tens=0, running=0, done=0 immediately (asynchronously). After release, state is IDLE.
- Target 12, sw=1, press pb, then 12 ticks:
  - running rises SYNC_STAGES+1 cycles after pb.
  - Count steps 00,01,...,09,10,11,12.
  - done_pulse fires once on the 12th tick; done stays high; further ticks leave the count at 12.
- Target 25, start, 7 ticks, pb press (PAUSE), then 5 ticks -> count stays 07. Press pb again, then 18 ticks -> done with count 25.
- Target 99, start, 30 ticks with sw=0 then 99 ticks with sw=1:
  - Count stays 00 during the sw=0 ticks.
  - Ones wraps 9->0 with a tens carry each decade.
  - done at 99.
- Target tens=4, ones=0xC (invalid BCD), start -> latched target 49; done after 49 ticks.
- Target 00 and start -> DONE immediately with done_pulse. Then:
  - Assert clr in the same cycle as a pb_rise and a tick -> IDLE, count 00, no start.
  - A later pb press in DONE returns to IDLE.

Source files
------------

// File: rtl/bcd_countup_timer.sv
// Two-digit BCD count-up timer. It counts from 00 up to a target that is
// latched at start. A start/pause pushbutton and an enable switch control it,
// and it flags done when the count reaches the target.
module bcd_countup_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_DIGIT   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       sw,
  input  logic       pb,
  input  logic       clr,
  input  logic [3:0] tgt_ones,
  input  logic [3:0] tgt_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  localparam logic [3:0] MaxDigitC = 4'(MAX_DIGIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] pb_sync_q;
  logic                   pb_edge_q;
  logic                   pb_rise;
  logic [3:0]             ones_q;
  logic [3:0]             tens_q;
  logic [3:0]             tgt_ones_q;
  logic [3:0]             tgt_tens_q;
  logic                   running_q;
  logic                   done_q;
  logic                   done_pulse_q;
  logic [3:0]             tgt_ones_d;
  logic [3:0]             tgt_tens_d;
  logic                   tgt_zero_d;
  logic [3:0]             inc_ones_d;
  logic [3:0]             inc_tens_d;
  logic                   hit_target_d;

  // Bring the raw pushbutton into the clock domain and keep its last synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_sync_q <= '0;
      pb_edge_q <= 1'b0;
    end else begin
      pb_sync_q <= {pb_sync_q[SYNC_STAGES-2:0], pb};
      pb_edge_q <= pb_sync_q[SYNC_STAGES-1];
    end
  end

  assign pb_rise = pb_sync_q[SYNC_STAGES-1] & ~pb_edge_q;

  // Clamp the incoming target and precompute the BCD increment and the target match.
  always_comb begin
    tgt_ones_d   = (tgt_ones > MaxDigitC) ? MaxDigitC : tgt_ones;
    tgt_tens_d   = (tgt_tens > MaxDigitC) ? MaxDigitC : tgt_tens;
    tgt_zero_d   = (tgt_ones_d == 4'd0) && (tgt_tens_d == 4'd0);
    inc_ones_d   = ones_q + 4'd1;
    inc_tens_d   = tens_q;
    if (ones_q == 4'd9) begin
      inc_ones_d = 4'd0;
      inc_tens_d = tens_q + 4'd1;
    end
    hit_target_d = (inc_ones_d == tgt_ones_q) && (inc_tens_d == tgt_tens_q);
  end

  // Control FSM: the count, the latched target and the status outputs all update here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ones_q       <= 4'd0;
      tens_q       <= 4'd0;
      tgt_ones_q   <= 4'd0;
      tgt_tens_q   <= 4'd0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (clr) begin
        state_q   <= IDLE;
        ones_q    <= 4'd0;
        tens_q    <= 4'd0;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            if (pb_rise) begin
              tgt_ones_q <= tgt_ones_d;
              tgt_tens_q <= tgt_tens_d;
              if (tgt_zero_d) begin
                state_q      <= DONE;
                done_q       <= 1'b1;
                done_pulse_q <= 1'b1;
              end else begin
                state_q   <= RUN;
                running_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pb_rise) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (tick && sw) begin
              ones_q <= inc_ones_d;
              tens_q <= inc_tens_d;
              if (hit_target_d) begin
                state_q      <= DONE;
                running_q    <= 1'b0;
                done_q       <= 1'b1;
                done_pulse_q <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (pb_rise) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          DONE: begin
            if (pb_rise) begin
              state_q <= IDLE;
              done_q  <= 1'b0;
              ones_q  <= 4'd0;
              tens_q  <= 4'd0;
            end
          end
          default: begin
            state_q   <= IDLE;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ones       = ones_q;
  assign tens       = tens_q;
  assign running    = running_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_bcd_countup_timer.sv
// Self-checking bench for bcd_countup_timer. It runs a vector table, then
// directed corner sequences, then random stimulus against a counting model.
module tb_bcd_countup_timer;

  localparam int S = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       sw = 1'b0;
  logic       pb = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] tgt_ones = 4'd0;
  logic [3:0] tgt_tens = 4'd0;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;
  logic       done;
  logic       done_pulse;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: the count is a plain integer 0..99, and the target is a decimal number.
  int   mState;
  int   mCnt;
  int   mTgt;
  logic mPulse;
  bit   mHist [0:S+1];

  typedef struct {
    logic       tick;
    logic       sw;
    logic       pb;
    logic       clr;
    logic [3:0] eOnes;
    logic [3:0] eTens;
    logic       eRun;
    logic       eDone;
    logic       ePulse;
  } vec_t;

  vec_t vecs [10];
  logic pbLevel;

  bcd_countup_timer #(.SYNC_STAGES(S), .MAX_DIGIT(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .sw         (sw),
    .pb         (pb),
    .clr        (clr),
    .tgt_ones   (tgt_ones),
    .tgt_tens   (tgt_tens),
    .ones       (ones),
    .tens       (tens),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  function automatic int clampDigit(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic modelReset();
    mState = M_IDLE;
    mCnt   = 0;
    mTgt   = 0;
    mPulse = 1'b0;
    for (int i = 0; i <= S + 1; i++) mHist[i] = 1'b0;
  endtask

  // A press takes effect S edges after pb is first sampled high.
  task automatic modelEdge(input logic t, input logic s, input logic p, input logic c);
    bit rise;
    for (int i = S + 1; i > 0; i--) mHist[i] = mHist[i-1];
    mHist[0] = p;
    rise = mHist[S] && !mHist[S+1];
    mPulse = 1'b0;
    if (c) begin
      mState = M_IDLE;
      mCnt   = 0;
    end else begin
      case (mState)
        M_IDLE: begin
          mCnt = 0;
          if (rise) begin
            mTgt = clampDigit(tgt_tens) * 10 + clampDigit(tgt_ones);
            if (mTgt == 0) begin
              mState = M_DONE;
              mPulse = 1'b1;
            end else begin
              mState = M_RUN;
            end
          end
        end
        M_RUN: begin
          if (rise) mState = M_PAUSE;
          else if (t && s) begin
            mCnt = mCnt + 1;
            if (mCnt == mTgt) begin
              mState = M_DONE;
              mPulse = 1'b1;
            end
          end
        end
        M_PAUSE: if (rise) mState = M_RUN;
        default: if (rise) begin
          mState = M_IDLE;
          mCnt   = 0;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic t, input logic s, input logic p, input logic c);
    tick = t;
    sw   = s;
    pb   = p;
    clr  = c;
    @(posedge clk);
    if (rst_n) modelEdge(t, s, p, c);
    #1;
  endtask

  task automatic cmp(input string name, input string fld, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, fld, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eO, input logic [3:0] eT,
                             input logic eR, input logic eD, input logic eP);
    cmp(name, "ones", {4'd0, ones}, {4'd0, eO});
    cmp(name, "tens", {4'd0, tens}, {4'd0, eT});
    cmp(name, "running", {7'd0, running}, {7'd0, eR});
    cmp(name, "done", {7'd0, done}, {7'd0, eD});
    cmp(name, "done_pulse", {7'd0, done_pulse}, {7'd0, eP});
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, 4'(mCnt % 10), 4'(mCnt / 10), mState == M_RUN, mState == M_DONE, mPulse);
  endtask

  task automatic pressPb(input logic s);
    for (int i = 0; i < S + 1; i++) begin
      applyStimulus(1'b0, s, 1'b1, 1'b0);
      checkModel("press");
    end
    for (int i = 0; i < S + 1; i++) begin
      applyStimulus(1'b0, s, 1'b0, 1'b0);
      checkModel("release");
    end
  endtask

  task automatic ticks(input int n, input logic s, input string name);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, s, 1'b0, 1'b0);
      checkModel(name);
    end
  endtask

  task automatic clearToIdle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("clear", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};

    modelReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;

    $display("[TB] vector table, target 03");
    tgt_ones = 4'd3;
    tgt_tens = 4'd0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].tick, vecs[i].sw, vecs[i].pb, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].eOnes, vecs[i].eTens,
                  vecs[i].eRun, vecs[i].eDone, vecs[i].ePulse);
    end
    for (int i = 0; i < S + 1; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkModel("vecRelease");
    end

    $display("[TB] async reset at count 37");
    tgt_tens = 4'd5;
    tgt_ones = 4'd0;
    pressPb(1'b1);
    ticks(37, 1'b1, "to37");
    checkOutput("at37", 4'd7, 4'd3, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncRst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    modelReset();
    #3 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("postRst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] target 12");
    tgt_tens = 4'd1;
    tgt_ones = 4'd2;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("startWait1", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("startWait2", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("startRun", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < S + 1; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkModel("rel12");
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t12_%0d", k), 4'(k % 10), 4'(k / 10), k < 12, k == 12, k == 12);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("hold12", 4'd2, 4'd1, 1'b0, 1'b1, 1'b0);
    end
    clearToIdle();

    $display("[TB] target 25 with pause");
    tgt_tens = 4'd2;
    tgt_ones = 4'd5;
    pressPb(1'b1);
    ticks(7, 1'b1, "run7");
    checkOutput("prePause", 4'd7, 4'd0, 1'b1, 1'b0, 1'b0);
    pressPb(1'b1);
    ticks(5, 1'b1, "paused");
    checkOutput("paused7", 4'd7, 4'd0, 1'b0, 1'b0, 1'b0);
    pressPb(1'b1);
    ticks(18, 1'b1, "resume");
    checkOutput("done25", 4'd5, 4'd2, 1'b0, 1'b1, 1'b1);
    clearToIdle();

    $display("[TB] target 99 with switch off then on");
    tgt_tens = 4'd9;
    tgt_ones = 4'd9;
    pressPb(1'b1);
    ticks(30, 1'b0, "swOff");
    checkOutput("swOffHold", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 99; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t99_%0d", k), 4'(k % 10), 4'(k / 10), k < 99, k == 99, k == 99);
    end
    clearToIdle();

    $display("[TB] clamped target 4C");
    tgt_tens = 4'd4;
    tgt_ones = 4'hC;
    pressPb(1'b1);
    tgt_tens = 4'd1;
    tgt_ones = 4'd1;
    ticks(48, 1'b1, "clamp");
    checkOutput("pre49", 4'd8, 4'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clamp49", 4'd9, 4'd4, 1'b0, 1'b1, 1'b1);
    clearToIdle();

    $display("[TB] target 00 and clear priority");
    tgt_tens = 4'd0;
    tgt_ones = 4'd0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkModel("zeroWait1");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkModel("zeroWait2");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("zeroDone", 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("zeroHold", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkModel("zeroRel");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkModel("zeroRel");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkModel("clrWait1");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkModel("clrWait2");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("clrPrio", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("noStart", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < S + 1; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkModel("zeroRel2");
    end
    pressPb(1'b1);
    checkOutput("zeroAgain", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    pressPb(1'b1);
    checkOutput("doneToIdle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] random stimulus");
    pbLevel = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) pbLevel = ~pbLevel;
      if ($urandom_range(0, 31) == 0) begin
        tgt_tens = 4'($urandom_range(0, 3));
        tgt_ones = 4'($urandom_range(0, 15));
      end
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), pbLevel,
                    ($urandom_range(0, 63) == 0));
      checkModel("rand");
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
